sram: RTL and testbench
=======================

// Module: sram
//
// PURPOSE
// Single-port synchronous RAM with per-byte write enables and one-cycle registered read.
// Serves as the storage primitive of the non-blocking data cache: one instance each per way
// for line data and for tags, plus one shared instance for the valid/dirty bits.
// Because valid bits live in it, all contents clear to zero on reset.
//
// PARAMETERS
// DATA_WIDTH  64    word width in bits; any value >= 1, need not be a multiple of 8
// NUM_WORDS   1024  number of words (depth); any value >= 2, need not be a power of two
// (derived) AW = $clog2(NUM_WORDS), BW = (DATA_WIDTH+7)/8
//
// PORTS
// clk_i    in   1           clock, all state updates on rising edge
// rst_ni   in   1           asynchronous active-low reset
// req_i    in   1           access request (read or write) this cycle
// we_i     in   1           1 = write, 0 = read; ignored when req_i=0
// addr_i   in   AW          word address
// wdata_i  in   DATA_WIDTH  write data
// be_i     in   BW          byte enables; bit k covers wdata_i[8k+7:8k]
// rdata_o  out  DATA_WIDTH  read data, registered
//
// BEHAVIOUR
// - Reset (rst_ni=0, asynchronous): every memory word := 0; rdata_o := 0.
//   Holds while asserted; inputs are ignored during reset.
// - Write (req_i=1, we_i=1) at a rising edge:
//   - for each k with be_i[k]=1: mem[addr_i][byte k] := wdata_i[byte k]; other bytes keep their value.
//   - be_i=0 leaves memory untouched.
// - Partial top byte: when DATA_WIDTH%8 != 0, be_i[BW-1] enables only bits
//   [DATA_WIDTH-1:8*(BW-1)].
// - Read (req_i=1, we_i=0) at edge N: rdata_o = mem[addr_i] (value before edge N), valid from
//   edge N and stable until the next read; latency exactly 1 cycle.
// - rdata_o changes only on a read request. Writes and idle cycles (req_i=0) hold the last
//   read value. No write-through to rdata_o.
// - Back-to-back: a read in the cycle after a write to the same address returns the new data.
//   Reads issue every cycle at full throughput, with no stalls and no grant handshake.
// - Out of range (addr_i >= NUM_WORDS, possible only when NUM_WORDS is not a power of 2):
//   write is dropped; read loads rdata_o := 0.
// - rdata_o never carries X after reset, including reads of never-written words (they return 0).
// - Reset asserted mid-operation: any pending edge's write is lost, contents clear,
//   rdata_o := 0 immediately (no clock needed).
// - Behavioural flop array; no SRAM macro dependency, no initial blocks needed for correctness.
//
// TESTING
// 1. Reset then read addr 5 -> rdata_o=0 one cycle later; likewise for addr 0 and addr NUM_WORDS-1.
// 2. Write addr 3 data 0x1122334455667788 be=0xFF, read addr 3 next cycle
//    -> rdata_o=0x1122334455667788 after 1 edge.
// 3. Byte-enable merge:
//    - write addr 3 data 0xAAAAAAAAAAAAAAAA be=0x0F, read addr 3 -> 0x11223344AAAAAAAA.
//    - write with be=0x00, read -> unchanged.
// 4. Hold behaviour: after reading 0x11223344AAAAAAAA, idle 3 cycles then write addr 7
//    -> rdata_o stays 0x11223344AAAAAAAA throughout.
// 5. Narrow widths:
//    - DATA_WIDTH=2, NUM_WORDS=256 (valid/dirty style): write 2'b11 be=1 to addr 255,
//      read -> 2'b11.
//    - DATA_WIDTH=44: be[5] writes bits [43:40] only.
// 6. Async reset mid-stream: write nonzero to addr 9, pulse rst_ni low between edges
//    -> rdata_o=0 without a clock; read addr 9 -> 0.

Source files
------------

// File: rtl/sram.sv
// sram: single-port synchronous RAM with per-byte write enables and a registered read port.
// Every word and the read register clear asynchronously on reset.
module sram #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_WORDS = 1024,
    localparam int AW = $clog2(NUM_WORDS),
    localparam int BW = (DATA_WIDTH + 7) / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [BW-1:0]         be_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    localparam logic [AW:0] DEPTH = (AW + 1)'(NUM_WORDS);
    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
    logic [DATA_WIDTH-1:0] bit_mask;
    logic in_range;
    assign in_range = {1'b0, addr_i} < DEPTH;
    // a partial top byte simply has fewer bits mapped to its enable
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_mask
        assign bit_mask[i] = be_i[i/8];
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int w = 0; w < NUM_WORDS; w++) mem[w] <= '0;
            rdata_o <= '0;
        end else if (req_i) begin
            if (we_i && in_range) mem[addr_i] <= (mem[addr_i] & ~bit_mask) | (wdata_i & bit_mask);
            if (!we_i) rdata_o <= in_range ? mem[addr_i] : '0;
        end
    end
endmodule

// File: tb/tb_sram.sv
// tb_sram: directed and random checks of three sram configurations against array models.
module tb_sram;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;
    logic r0, w0, r1, w1, r2, w2;
    logic [9:0] a0;
    logic [63:0] d0, q0;
    logic [7:0] b0;
    logic [7:0] a1;
    logic [1:0] d1, q1;
    logic [0:0] b1;
    logic [4:0] a2;
    logic [43:0] d2, q2;
    logic [5:0] b2;
    logic [63:0] m0 [1024];
    logic [1:0] m1 [256];
    logic [43:0] m2 [20];
    logic [63:0] e0;
    logic [1:0] e1;
    logic [43:0] e2;
    int checks = 0;
    int failures = 0;

    sram #(.DATA_WIDTH(64), .NUM_WORDS(1024)) u0 (.clk_i(clk), .rst_ni(rst_n), .req_i(r0), .we_i(w0),
        .addr_i(a0), .wdata_i(d0), .be_i(b0), .rdata_o(q0));
    sram #(.DATA_WIDTH(2), .NUM_WORDS(256)) u1 (.clk_i(clk), .rst_ni(rst_n), .req_i(r1), .we_i(w1),
        .addr_i(a1), .wdata_i(d1), .be_i(b1), .rdata_o(q1));
    sram #(.DATA_WIDTH(44), .NUM_WORDS(20)) u2 (.clk_i(clk), .rst_ni(rst_n), .req_i(r2), .we_i(w2),
        .addr_i(a2), .wdata_i(d2), .be_i(b2), .rdata_o(q2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_models();
        for (int i = 0; i < 1024; i++) m0[i] = '0;
        for (int i = 0; i < 256; i++) m1[i] = '0;
        for (int i = 0; i < 20; i++) m2[i] = '0;
        e0 = '0;
        e1 = '0;
        e2 = '0;
    endtask

    task automatic idle();
        r0 = 0; w0 = 0; a0 = '0; d0 = '0; b0 = '0;
        r1 = 0; w1 = 0; a1 = '0; d1 = '0; b1 = '0;
        r2 = 0; w2 = 0; a2 = '0; d2 = '0; b2 = '0;
    endtask

    // one clock edge: apply the access rules to the models, then compare all three outputs
    task automatic step(input string tag);
        logic [47:0] t, wd;
        @(posedge clk);
        if (rst_n) begin
            if (r0) begin
                if (w0) begin
                    for (int k = 0; k < 8; k++) if (b0[k]) m0[a0][8*k +: 8] = d0[8*k +: 8];
                end else e0 = m0[a0];
            end
            if (r1) begin
                if (w1) begin
                    if (b1[0]) m1[a1] = d1;
                end else e1 = m1[a1];
            end
            if (r2) begin
                if (a2 < 20) begin
                    if (w2) begin
                        t = {4'b0, m2[a2]};
                        wd = {4'b0, d2};
                        for (int k = 0; k < 6; k++) if (b2[k]) t[8*k +: 8] = wd[8*k +: 8];
                        m2[a2] = t[43:0];
                    end else e2 = m2[a2];
                end else if (!w2) e2 = '0;
            end
        end
        #1;
        chk({tag, "/q0"}, q0, e0);
        chk({tag, "/q1"}, {62'b0, q1}, {62'b0, e1});
        chk({tag, "/q2"}, {20'b0, q2}, {20'b0, e2});
    endtask

    initial begin
        rst_n = 0;
        idle();
        clear_models();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_q0", q0, 64'h0);
        chk("reset_q1", {62'b0, q1}, 64'h0);
        chk("reset_q2", {20'b0, q2}, 64'h0);
        @(negedge clk);
        rst_n = 1;
        // reads of never-written words, including the top address of each instance
        r0 = 1; a0 = 10'd5; r1 = 1; a1 = 8'd255; r2 = 1; a2 = 5'd19;
        step("rd_fresh_a");
        a0 = 10'd0; a1 = 8'd0; a2 = 5'd0;
        step("rd_fresh_b");
        a0 = 10'd1023;
        step("rd_fresh_c");
        idle();
        // full write then immediate read-back
        r0 = 1; w0 = 1; a0 = 10'd3; d0 = 64'h1122334455667788; b0 = 8'hFF;
        step("wr_full");
        w0 = 0;
        step("rd_full");
        chk("full_const", q0, 64'h1122334455667788);
        w0 = 1; d0 = 64'hAAAAAAAAAAAAAAAA; b0 = 8'h0F;
        step("wr_be0f");
        w0 = 0;
        step("rd_be0f");
        chk("be0f_const", q0, 64'h11223344AAAAAAAA);
        w0 = 1; d0 = 64'h5555555555555555; b0 = 8'h00;
        step("wr_be00");
        w0 = 0;
        step("rd_be00");
        chk("be00_const", q0, 64'h11223344AAAAAAAA);
        // idle cycles and an unrelated write must hold the last read value
        idle();
        repeat (3) step("hold_idle");
        r0 = 1; w0 = 1; a0 = 10'd7; d0 = 64'hFFFF0000FFFF0000; b0 = 8'hFF;
        step("hold_wr");
        chk("hold_const", q0, 64'h11223344AAAAAAAA);
        idle();
        // narrow configurations: 2-bit words and a 44-bit word with a partial top byte
        r1 = 1; w1 = 1; a1 = 8'd255; d1 = 2'b11; b1 = 1'b1;
        r2 = 1; w2 = 1; a2 = 5'd4; d2 = '1; b2 = 6'h3F;
        step("narrow_wr1");
        w1 = 0;
        d2 = 44'h0; b2 = 6'b100000;
        step("narrow_wr2");
        w2 = 0;
        step("narrow_rd");
        chk("dw2_const", {62'b0, q1}, 64'h3);
        chk("dw44_const", {20'b0, q2}, 64'h000_00FF_FFFF_FFFF);
        // out-of-range on the 20-word instance: write dropped, read returns zero
        w2 = 1; a2 = 5'd25; d2 = 44'h123_4567_89AB; b2 = 6'h3F;
        step("oor_wr");
        w2 = 0;
        step("oor_rd");
        chk("oor_const", {20'b0, q2}, 64'h0);
        idle();
        for (int n = 0; n < 400; n++) begin
            r0 = 1'($urandom); w0 = 1'($urandom); a0 = 10'($urandom_range(0, 15));
            d0 = {$urandom, $urandom}; b0 = 8'($urandom);
            r1 = 1'($urandom); w1 = 1'($urandom); a1 = 8'($urandom_range(250, 255));
            d1 = 2'($urandom); b1 = 1'($urandom);
            r2 = 1'($urandom); w2 = 1'($urandom); a2 = 5'($urandom_range(0, 31));
            d2 = 44'({$urandom, $urandom}); b2 = 6'($urandom);
            step("rnd");
        end
        idle();
        // asynchronous reset between edges with a write pending
        r0 = 1; w0 = 1; a0 = 10'd9; d0 = 64'hDEADBEEFCAFEF00D; b0 = 8'hFF;
        step("ar_wr");
        w0 = 0;
        step("ar_rd");
        chk("ar_pre", q0, 64'hDEADBEEFCAFEF00D);
        w0 = 1; d0 = 64'h0123456789ABCDEF;
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("ar_async_q0", q0, 64'h0);
        chk("ar_async_q1", {62'b0, q1}, 64'h0);
        chk("ar_async_q2", {20'b0, q2}, 64'h0);
        clear_models();
        @(negedge clk);
        rst_n = 1;
        w0 = 0;
        step("ar_rd9");
        chk("ar_rd9_const", q0, 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
